buckeye_shift_ctrl: RTL and testbench



---
 rtl/buckeye_shift_ctrl.sv | 141 ++++++++++++++
 tb/tb_buckeye_shift_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buckeye_shift_ctrl.sv
// Serial configuration controller for the six Buckeye shaper chips: shifts a
// parallel pattern out MSB-first with a divided shift clock and captures readback.
module buckeye_shift_ctrl #(
   parameter int NBITS   = 48,
   parameter int CLK_DIV = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [NBITS-1:0] LOAD_DATA,
   input  logic [5:0]       CHIP_MASK,
   input  logic [2:0]       RDBK_SEL,
   output logic             BUSY,
   output logic             DONE,
   output logic [6:1]       TO_BKY,
   output logic [6:1]       BKY_CLK,
   input  logic [6:1]       BKY_RTN,
   output logic [NBITS-1:0] RDBK
);

   localparam int         CW       = $clog2(NBITS + 1);
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

   state_t           state, state_nx;
   logic [7:0]       div, div_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [NBITS-1:0] tx, tx_nx;
   logic [6:1]       mask, mask_nx;
   logic [6:1]       to_nx, bclk_nx;
   logic             busy_nx, done_nx, capture;
   logic [NBITS-1:0] rb [1:6];

   // Outputs are computed one cycle ahead so the registered pins line up with state.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_nx = state;
      div_nx   = div;
      cnt_nx   = cnt;
      tx_nx    = tx;
      mask_nx  = mask;
      to_nx    = TO_BKY;
      bclk_nx  = BKY_CLK;
      busy_nx  = BUSY;
      done_nx  = 1'b0;
      capture  = 1'b0;
      unique case (state)
         IDLE: begin
            if (START) begin
               state_nx = LOW;
               tx_nx    = LOAD_DATA;
               mask_nx  = CHIP_MASK;
               cnt_nx   = '0;
               div_nx   = DIV_LAST;
               busy_nx  = 1'b1;
               bclk_nx  = '0;
               to_nx    = CHIP_MASK & {6{LOAD_DATA[NBITS-1]}};
            end
         end
         LOW: begin
            if (div == 8'd0) begin
               state_nx = HIGH;
               div_nx   = DIV_LAST;
               capture  = 1'b1;
               bclk_nx  = mask;
            end else begin
               div_nx = div - 8'd1;
            end
         end
         HIGH: begin
            if (div == 8'd0) begin
               tx_nx   = tx << 1;
               cnt_nx  = cnt + CW'(1);
               div_nx  = DIV_LAST;
               bclk_nx = '0;
               if (cnt == CW'(NBITS - 1)) begin
                  state_nx = FIN;
                  to_nx    = '0;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = LOW;
                  to_nx    = mask & {6{tx_nx[NBITS-1]}};
               end
            end else begin
               div_nx = div - 8'd1;
            end
         end
         FIN: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         div     <= '0;
         cnt     <= '0;
         tx      <= '0;
         mask    <= '0;
         TO_BKY  <= '0;
         BKY_CLK <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         state   <= state_nx;
         div     <= div_nx;
         cnt     <= cnt_nx;
         tx      <= tx_nx;
         mask    <= mask_nx;
         TO_BKY  <= to_nx;
         BKY_CLK <= bclk_nx;
         BUSY    <= busy_nx;
         DONE    <= done_nx;
      end
   end

   // Return data is sampled on the same CLK edge that raises BKY_CLK, i.e. before the chip shifts.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         // NOTE: the readback bank is a handful of flops, not a RAM, so it is reset with everything else.
         for (int i = 1; i <= 6; i++) rb[i] <= '0;
         RDBK <= '0;
      end else begin
         for (int i = 1; i <= 6; i++) begin
            if (capture && mask[i]) rb[i] <= {rb[i][NBITS-2:0], BKY_RTN[i]};
         end
         case (RDBK_SEL)
            3'd1:    RDBK <= rb[1];
            3'd2:    RDBK <= rb[2];
            3'd3:    RDBK <= rb[3];
            3'd4:    RDBK <= rb[4];
            3'd5:    RDBK <= rb[5];
            3'd6:    RDBK <= rb[6];
            default: RDBK <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_buckeye_shift_ctrl.sv
// Bench for buckeye_shift_ctrl: behavioural chip models, edge/stability monitors,
// and a per-chip register model predicting readback from shift history.
module tb_buckeye_shift_ctrl;
   localparam int NB = 48;

   logic          clk = 1'b0;
   logic          rst, start4, start1, preload;
   logic [NB-1:0] load_data;
   logic [5:0]    chip_mask, mon_mask;
   logic [2:0]    rdbk_sel;
   logic          busy4, done4, busy1, done1;
   logic [6:1]    to4, bclk4, rtn4, to1, bclk1;
   logic [6:1]    rtn1 = '0;
   logic [NB-1:0] rdbk4, rdbk1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   buckeye_shift_ctrl #(.NBITS(NB), .CLK_DIV(4)) dut (
      .CLK(clk), .RST(rst), .START(start4), .LOAD_DATA(load_data), .CHIP_MASK(chip_mask),
      .RDBK_SEL(rdbk_sel), .BUSY(busy4), .DONE(done4), .TO_BKY(to4), .BKY_CLK(bclk4),
      .BKY_RTN(rtn4), .RDBK(rdbk4));

   buckeye_shift_ctrl #(.NBITS(NB), .CLK_DIV(1)) dut_fast (
      .CLK(clk), .RST(rst), .START(start1), .LOAD_DATA(load_data), .CHIP_MASK(chip_mask),
      .RDBK_SEL(rdbk_sel), .BUSY(busy1), .DONE(done1), .TO_BKY(to1), .BKY_CLK(bclk1),
      .BKY_RTN(rtn1), .RDBK(rdbk1));

   // Behavioural Buckeye chips: shift in TO_BKY on rising BKY_CLK, MSB returned.
   logic [NB-1:0] chip [1:6];
   logic [NB-1:0] init_val [1:6];
   for (genvar g = 1; g <= 6; g++) begin : g_chip
      assign rtn4[g] = chip[g][NB-1];
      always @(posedge bclk4[g] or posedge preload) begin
         if (preload) chip[g] <= init_val[g];
         else         chip[g] <= {chip[g][NB-2:0], to4[g]};
      end
   end

   // Monitors: cumulative counters, only ever written here.
   int            edges4 [1:6] = '{default: 0};
   int            viol4 = 0, stray4 = 0, dones4 = 0, edges1 = 0, viol1 = 0;
   logic [NB-1:0] bits4 = '0;
   logic [6:1]    pclk4 = '0, pto4 = '0, pclk1 = '0, pto1 = '0;
   logic [6:1]    rise4, rise1;
   assign rise4 = bclk4 & ~pclk4;
   assign rise1 = bclk1 & ~pclk1;

   always @(negedge clk) begin
      for (int i = 1; i <= 6; i++) if (rise4[i]) edges4[i] <= edges4[i] + 1;
      if (rise4[1]) bits4 <= {bits4[NB-2:0], to4[1]};
      if (|(rise4 & (to4 ^ pto4))) viol4 <= viol4 + 1;
      if (|((bclk4 | to4) & ~mon_mask)) stray4 <= stray4 + 1;
      if (done4) dones4 <= dones4 + 1;
      if (|rise1) edges1 <= edges1 + $countones(rise1);
      if (|(rise1 & (to1 ^ pto1))) viol1 <= viol1 + 1;
      pclk4 <= bclk4;
      pto4  <= to4;
      pclk1 <= bclk1;
      pto1  <= to1;
   end

   // Reference model: chip contents and expected readback per chip.
   logic [NB-1:0] m_chip [1:6];
   logic [NB-1:0] m_rb   [1:6];
   int d_edges [1:6];
   int d_viol, d_stray, d_done, d_edges1, d_viol1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic read_rb(input logic [2:0] sel, input logic [NB-1:0] exp, input string tag);
      @(negedge clk);
      rdbk_sel = sel;
      repeat (2) @(negedge clk);
      chk(tag, 64'(rdbk4), 64'(exp));
   endtask

   task automatic read_all(input string tag);
      for (int s = 1; s <= 6; s++) read_rb(3'(s), m_rb[s], $sformatf("%s_sel%0d", tag, s));
   endtask

   task automatic run(input bit fast, input logic [NB-1:0] data, input logic [5:0] mask,
                      input int restart_cyc, output int done_cyc);
      int e0 [1:6];
      int v0, s0, dn0, e10, v10, c0;
      @(negedge clk);
      #1;
      for (int i = 1; i <= 6; i++) e0[i] = edges4[i];
      v0 = viol4; s0 = stray4; dn0 = dones4; e10 = edges1; v10 = viol1;
      load_data = data;
      chip_mask = mask;
      mon_mask  = fast ? 6'h00 : mask;
      if (fast) start1 = 1'b1; else start4 = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      start4 = 1'b0;
      start1 = 1'b0;
      load_data = ~data;
      chip_mask = ~mask;
      done_cyc = -1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (!fast) start4 = (restart_cyc != 0) && (cyc - c0 + 1 == restart_cyc);
         if (fast ? done1 : done4) begin
            done_cyc = cyc - c0 + 1;
            break;
         end
      end
      start4 = 1'b0;
      @(negedge clk);
      #1;
      chk("done_pulse_width", 64'(fast ? done1 : done4), 64'(0));
      for (int i = 1; i <= 6; i++) d_edges[i] = edges4[i] - e0[i];
      d_viol = viol4 - v0; d_stray = stray4 - s0; d_done = dones4 - dn0;
      d_edges1 = edges1 - e10; d_viol1 = viol1 - v10;
      if (!fast) begin
         for (int i = 1; i <= 6; i++) begin
            if (mask[i-1]) begin
               m_rb[i]   = m_chip[i];
               m_chip[i] = data;
            end
         end
      end
   endtask

   initial begin
      int            dc, c0, tot;
      logic [NB-1:0] d;
      logic [5:0]    m;
      rst = 1'b1; start4 = 1'b0; start1 = 1'b0; preload = 1'b0;
      load_data = '0; chip_mask = '0; rdbk_sel = '0; mon_mask = '0;
      for (int i = 1; i <= 6; i++) begin
         init_val[i] = {16'($urandom), 32'($urandom)};
         m_chip[i]   = init_val[i];
         m_rb[i]     = '0;
      end
      #1 preload = 1'b1;
      #1 preload = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy4), 64'(0));
      chk("rst_done", 64'(done4), 64'(0));
      chk("rst_to_bky", 64'(to4), 64'(0));
      chk("rst_bky_clk", 64'(bclk4), 64'(0));
      chk("rst_rdbk", 64'(rdbk4), 64'(0));
      rst = 1'b0;

      // Single chip, alternating pattern, exact timing.
      run(1'b0, 48'hA5A5_A5A5_A5A5, 6'b000001, 0, dc);
      chk("t1_done_cycle", 64'(dc), 64'(385));
      chk("t1_edges_chip1", 64'(d_edges[1]), 64'(48));
      tot = d_edges[2] + d_edges[3] + d_edges[4] + d_edges[5] + d_edges[6];
      chk("t1_edges_others", 64'(tot), 64'(0));
      chk("t1_bitstream", 64'(bits4), 64'(48'hA5A5_A5A5_A5A5));
      chk("t1_stray_pins", 64'(d_stray), 64'(0));
      chk("t1_setup_viol", 64'(d_viol), 64'(0));
      chk("t1_done_count", 64'(d_done), 64'(1));
      read_rb(3'd1, m_rb[1], "t1_rdbk_chip1");

      // All chips: write pattern, then flush it back out.
      run(1'b0, 48'h1234_5678_9ABC, 6'h3F, 0, dc);
      run(1'b0, 48'h0, 6'h3F, 0, dc);
      for (int s = 1; s <= 6; s++)
         read_rb(3'(s), 48'h1234_5678_9ABC, $sformatf("t2_rdbk_sel%0d", s));

      // Single masked-in chip; others keep previous readback.
      run(1'b0, {16'($urandom), 32'($urandom)}, 6'b000100, 0, dc);
      read_rb(3'd3, m_rb[3], "t3_rdbk_sel3");
      read_rb(3'd1, 48'h1234_5678_9ABC, "t3_rdbk_sel1_kept");
      read_rb(3'd0, 48'h0, "t3_rdbk_sel0");
      read_rb(3'd7, 48'h0, "t3_rdbk_sel7");

      // Random patterns and masks against the chip model.
      for (int k = 0; k < 4; k++) begin
         d = {16'($urandom), 32'($urandom)};
         m = 6'($urandom_range(1, 63));
         run(1'b0, d, m, 0, dc);
         chk($sformatf("rnd%0d_done_cycle", k), 64'(dc), 64'(385));
         tot = 0;
         for (int i = 1; i <= 6; i++) tot += d_edges[i];
         chk($sformatf("rnd%0d_edges", k), 64'(tot), 64'(48 * $countones(m)));
         chk($sformatf("rnd%0d_stray", k), 64'(d_stray), 64'(0));
         read_all($sformatf("rnd%0d", k));
      end

      // START again at bit 10 is ignored.
      d = {16'($urandom), 32'($urandom)};
      run(1'b0, d, 6'b000001, 83, dc);
      chk("restart_done_cycle", 64'(dc), 64'(385));
      chk("restart_edges", 64'(d_edges[1]), 64'(48));
      chk("restart_done_count", 64'(d_done), 64'(1));
      chk("restart_bitstream", 64'(bits4), 64'(d));

      // Asynchronous reset during the high phase of bit 20.
      d = {16'($urandom), 32'($urandom)};
      @(negedge clk);
      load_data = d; chip_mask = 6'h3F; mon_mask = 6'h3F; start4 = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      start4 = 1'b0;
      for (int n = 0; n < 400 && (cyc - c0 + 1) < 166; n++) @(negedge clk);
      chk("abort_pre_clk_high", 64'(bclk4), 64'(6'h3F));
      #2 rst = 1'b1;
      #1;
      chk("abort_bky_clk", 64'(bclk4), 64'(0));
      chk("abort_to_bky", 64'(to4), 64'(0));
      chk("abort_busy", 64'(busy4), 64'(0));
      #2 rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         m_chip[i] = {m_chip[i][NB-22:0], d[NB-1:NB-21]};
         m_rb[i]   = '0;
      end
      read_rb(3'd2, 48'h0, "abort_rdbk_cleared");
      d = {16'($urandom), 32'($urandom)};
      run(1'b0, d, 6'h3F, 0, dc);
      chk("post_abort_done_cycle", 64'(dc), 64'(385));
      chk("post_abort_edges", 64'(d_edges[4]), 64'(48));
      read_all("post_abort");

      // Fastest divider: 2-cycle shift clock, data still set up a cycle ahead.
      m = 6'($urandom_range(1, 63));
      run(1'b1, {16'($urandom), 32'($urandom)}, m, 0, dc);
      chk("fast_done_cycle", 64'(dc), 64'(97));
      chk("fast_edges", 64'(d_edges1), 64'(48 * $countones(m)));
      chk("fast_setup_viol", 64'(d_viol1), 64'(0));
      run(1'b1, {16'($urandom), 32'($urandom)}, 6'h00, 0, dc);
      chk("fast_nomask_done_cycle", 64'(dc), 64'(97));
      chk("fast_nomask_edges", 64'(d_edges1), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
